// File: rtl/adc_avg_pkg.sv
// rtl/adc_avg_pkg.sv - shared widths and helpers for the ADC response averager
package adc_avg_pkg;

    localparam int DATA_W     = 12;
    localparam int CH_W       = 5;
    localparam int DROP_W     = 8;
    localparam int LOG2_N_DEF = 4;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/adc_resp_avg_if.sv
// rtl/adc_resp_avg_if.sv - averaged result stream with valid/ready handshake
interface adc_resp_avg_if;
    import adc_avg_pkg::*;

    logic              valid;
    logic [CH_W-1:0]   channel;
    logic [DATA_W-1:0] data;
    logic              ready;

    modport master (output valid, output channel, output data, input ready);
    modport slave  (input valid, input channel, input data, output ready);

endinterface

// File: rtl/adc_avg_out_reg.sv
// rtl/adc_avg_out_reg.sv - single-entry result holding register with drop indication
module adc_avg_out_reg
    import adc_avg_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic [CH_W-1:0]   load_channel,
    input  logic [DATA_W-1:0] load_data,
    output logic              full,
    output logic              dropped,
    adc_resp_avg_if.master    avg
);

    logic drain;

    assign drain   = avg.valid & avg.ready;
    assign full    = avg.valid;
    // A load that finds the register occupied and not draining is lost.
    assign dropped = load & avg.valid & ~avg.ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            avg.valid   <= 1'b0;
            avg.channel <= '0;
            avg.data    <= '0;
        end else if (load && (!avg.valid || avg.ready)) begin
            avg.valid   <= 1'b1;
            avg.channel <= load_channel;
            avg.data    <= load_data;
        end else if (drain) begin
            avg.valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/adc_resp_avg.sv
// rtl/adc_resp_avg.sv - per-channel block averaging of an ADC response stream
module adc_resp_avg
    import adc_avg_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int LOG2_N = LOG2_N_DEF
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              rsp_valid,
    input  logic [CH_W-1:0]   rsp_channel,
    input  logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_startofpacket,
    input  logic              rsp_endofpacket,
    input  logic              clear,
    output logic              avg_valid,
    output logic [CH_W-1:0]   avg_channel,
    output logic [DATA_W-1:0] avg_data,
    input  logic              avg_ready,
    output logic [DROP_W-1:0] drop_count
);

    localparam int ACC_W = DATA_W + LOG2_N;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

    logic [ACC_W-1:0]  acc [NUM_CH];
    logic [LOG2_N-1:0] cnt [NUM_CH];

    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              last;
    logic              done;
    logic [ACC_W-1:0]  sum;
    logic [DATA_W-1:0] result;
    logic              dropped;
    logic              full;
    logic              unused_pkt;

    assign unused_pkt = rsp_startofpacket ^ rsp_endofpacket ^ full;

    assign idx    = rsp_channel[IDX_W-1:0];
    assign accept = rsp_valid && ({1'b0, rsp_channel} < NUM_CH_L) && !clear;
    assign last   = &cnt[idx];
    assign sum    = acc[idx] + ACC_W'(rsp_data);
    assign result = sum[ACC_W-1:LOG2_N];
    assign done   = accept && last;

    // One read-modify-write per cycle on the addressed channel only.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n || clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
        end else if (accept) begin
            if (last) begin
                acc[idx] <= '0;
                cnt[idx] <= '0;
            end else begin
                acc[idx] <= sum;
                cnt[idx] <= cnt[idx] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            drop_count <= '0;
        end else if (dropped) begin
            drop_count <= sat_inc(drop_count);
        end
    end

    adc_resp_avg_if avg_if ();

    assign avg_if.ready = avg_ready;
    assign avg_valid    = avg_if.valid;
    assign avg_channel  = avg_if.channel;
    assign avg_data     = avg_if.data;

    adc_avg_out_reg u_out_reg (
        .clk          (clk_clk),
        .resetn       (reset_reset_n),
        .load         (done),
        .load_channel (rsp_channel),
        .load_data    (result),
        .full         (full),
        .dropped      (dropped),
        .avg          (avg_if.master)
    );

endmodule

// File: tb/tb_adc_resp_avg.sv
// tb/tb_adc_resp_avg.sv - scoreboard bench for adc_resp_avg against a per-channel sum model
module tb_adc_resp_avg;
    import adc_avg_pkg::*;

    localparam int NUM_CH = 8;
    localparam int LOG2_N = 4;
    localparam int NS     = 1 << LOG2_N;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              rsp_valid = 1'b0;
    logic [CH_W-1:0]   rsp_ch = '0;
    logic [DATA_W-1:0] rsp_d = '0;
    logic              sop = 1'b0;
    logic              eop = 1'b0;
    logic              clr = 1'b0;
    logic [DROP_W-1:0] drop_count;

    adc_resp_avg_if res_if ();

    always #5 clk = ~clk;

    adc_resp_avg #(.NUM_CH(NUM_CH), .LOG2_N(LOG2_N)) dut (
        .clk_clk           (clk),
        .reset_reset_n     (rstn),
        .rsp_valid         (rsp_valid),
        .rsp_channel       (rsp_ch),
        .rsp_data          (rsp_d),
        .rsp_startofpacket (sop),
        .rsp_endofpacket   (eop),
        .clear             (clr),
        .avg_valid         (res_if.valid),
        .avg_channel       (res_if.channel),
        .avg_data          (res_if.data),
        .avg_ready         (res_if.ready),
        .drop_count        (drop_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct { int ch; int d; } res_t;

    // Reference model: plain per-channel sums, one result slot, queue of expected transfers.
    int   m_sum [32];
    int   m_cnt [32];
    bit   m_full = 0;
    int   m_drop = 0;
    bit   m_done;
    res_t m_r;
    res_t exp_q [$];

    always @(posedge clk) begin
        if (!rstn) begin
            foreach (m_sum[i]) begin m_sum[i] = 0; m_cnt[i] = 0; end
            m_full = 0;
            m_drop = 0;
            exp_q.delete();
        end else begin
            m_done = 0;
            if (clr) begin
                foreach (m_sum[i]) begin m_sum[i] = 0; m_cnt[i] = 0; end
            end else if (rsp_valid && int'(rsp_ch) < NUM_CH) begin
                m_sum[rsp_ch] += int'(rsp_d);
                m_cnt[rsp_ch] += 1;
                if (m_cnt[rsp_ch] == NS) begin
                    m_done = 1;
                    m_r.ch = int'(rsp_ch);
                    m_r.d  = m_sum[rsp_ch] / NS;
                    m_sum[rsp_ch] = 0;
                    m_cnt[rsp_ch] = 0;
                end
            end
            if (m_done) begin
                if (!m_full || res_if.ready) begin
                    exp_q.push_back(m_r);
                    m_full = 1;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end else if (m_full && res_if.ready) begin
                m_full = 0;
            end
        end
    end

    bit   checking = 0;
    int   n_res = 0;
    int   last_ch = -1;
    int   last_d = -1;
    res_t got;

    always @(negedge clk) begin
        if (checking) begin
            chk("avg_valid", int'(res_if.valid), int'(m_full));
            chk("drop_count", int'(drop_count), m_drop);
            if (res_if.valid && res_if.ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    got = exp_q.pop_front();
                    chk("avg_channel", int'(res_if.channel), got.ch);
                    chk("avg_data", int'(res_if.data), got.d);
                    n_res++;
                    last_ch = int'(res_if.channel);
                    last_d  = int'(res_if.data);
                end
            end
        end
    end

    task automatic step(input bit v, input int ch, input int d, input bit c);
        rsp_valid = v;
        rsp_ch    = ch[CH_W-1:0];
        rsp_d     = d[DATA_W-1:0];
        clr       = c;
        sop       = 1'($urandom_range(0, 1));
        eop       = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    int n0;

    initial begin
        res_if.ready = 1'b1;
        rstn = 1'b0;
        idle(2);
        rstn = 1'b1;
        checking = 1;
        chk("reset_valid", int'(res_if.valid), 0);
        chk("reset_data", int'(res_if.data), 0);
        chk("reset_drop", int'(drop_count), 0);

        // Constant block on ch2, result visible right after the 16th sample edge
        n0 = n_res;
        for (int i = 0; i < NS; i++) step(1, 2, 100, 0);
        chk("s1_valid", int'(res_if.valid), 1);
        chk("s1_channel", int'(res_if.channel), 2);
        chk("s1_data", int'(res_if.data), 100);
        idle(2);
        chk("s1_count", n_res - n0, 1);

        // Ramp 0..15 truncates 120/16 to 7
        for (int i = 0; i < NS; i++) step(1, 0, i, 0);
        chk("s2_data", int'(res_if.data), 7);
        idle(2);

        // Held result with a dropped second result
        res_if.ready = 1'b0;
        for (int i = 0; i < NS; i++) step(1, 1, 200, 0);
        for (int i = 0; i < NS; i++) step(1, 3, 300, 0);
        idle(1);
        chk("s3_held_valid", int'(res_if.valid), 1);
        chk("s3_held_channel", int'(res_if.channel), 1);
        chk("s3_held_data", int'(res_if.data), 200);
        chk("s3_drop", int'(drop_count), 1);
        n0 = n_res;
        res_if.ready = 1'b1;
        idle(2);
        chk("s3_drained", n_res - n0, 1);
        chk("s3_drained_data", last_d, 200);

        // Out-of-range channel interleaved with full-scale ch4
        n0 = n_res;
        for (int i = 0; i < NS; i++) begin
            step(1, 9, $urandom_range(0, 4095), 0);
            step(1, 4, 4095, 0);
        end
        idle(2);
        chk("s4_count", n_res - n0, 1);
        chk("s4_channel", last_ch, 4);
        chk("s4_data", last_d, 4095);

        // Partial block discarded by reset, then by clear
        n0 = n_res;
        for (int i = 0; i < NS/2; i++) step(1, 5, 1000, 0);
        rstn = 1'b0;
        step(1, 5, 1000, 0);
        rstn = 1'b1;
        for (int i = 0; i < NS; i++) step(1, 5, 50, 0);
        idle(2);
        chk("s5_reset_count", n_res - n0, 1);
        chk("s5_reset_data", last_d, 50);
        n0 = n_res;
        for (int i = 0; i < NS/2; i++) step(1, 5, 1000, 0);
        step(1, 5, 1000, 1);
        for (int i = 0; i < NS; i++) step(1, 5, 50, 0);
        idle(2);
        chk("s5_clear_count", n_res - n0, 1);
        chk("s5_clear_data", last_d, 50);

        // Drive drop_count past saturation
        res_if.ready = 1'b0;
        for (int k = 0; k < 262; k++)
            for (int i = 0; i < NS; i++) step(1, k % NUM_CH, $urandom_range(0, 4095), 0);
        idle(1);
        chk("s6_drop_sat", int'(drop_count), 255);
        res_if.ready = 1'b1;
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            res_if.ready = ($urandom_range(0, 9) < 6);
            rstn = ($urandom_range(0, 999) >= 3);
            step($urandom_range(0, 9) < 7, $urandom_range(0, 11), $urandom_range(0, 4095),
                 $urandom_range(0, 99) == 0);
        end
        rstn = 1'b1;
        res_if.ready = 1'b1;
        idle(3);
        chk("queue_empty", exp_q.size(), 0);

        checking = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_resp_avg.md
ADC_RESP_AVG -- requirements
Module: adc_resp_avg

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of tracked channels (channels 0..NUM_CH-1, legal 1..32).
REQ-002 SHALL have parameter LOG2_N, default 4, log2 of samples averaged per result (legal 1..8).
REQ-003 SHALL have port clk_clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port reset_reset_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have ports rsp_valid (in, 1), rsp_channel (in, 5), rsp_data (in, 12), rsp_startofpacket (in, 1), rsp_endofpacket (in, 1): ADC response stream, no backpressure.
REQ-006 SHALL have port clear, input, 1, synchronous flush of all accumulators.
REQ-007 SHALL have ports avg_valid (out, 1), avg_channel (out, 5), avg_data (out, 12): averaged result stream.
REQ-008 SHALL have port avg_ready, input, 1, downstream accept for the averaged result stream.
REQ-009 SHALL have port drop_count, output, 8, saturating count of lost results.

Function
REQ-010 SHALL accept a sample when rsp_valid=1, rsp_channel<NUM_CH and clear=0; all other cycles leave state unchanged.
REQ-011 SHALL ignore rsp_startofpacket/rsp_endofpacket functionally.
REQ-012 SHALL keep per channel an accumulator of 12+LOG2_N bits and a sample counter of LOG2_N bits, no overflow possible.
REQ-013 SHALL, on accept with counter < 2^LOG2_N-1: accumulator += rsp_data, counter += 1.
REQ-014 SHALL, on accept with counter = 2^LOG2_N-1: form result = (accumulator + rsp_data) >> LOG2_N (truncating), reset that accumulator and counter to 0.
REQ-015 SHALL present the result on avg_valid/avg_channel/avg_data exactly one cycle after the completing sample cycle when the output register is empty or drained (avg_valid=1 and avg_ready=1) in that cycle.
REQ-016 SHALL hold avg_valid, avg_channel, avg_data stable while avg_valid=1 and avg_ready=0.
REQ-017 SHALL deassert avg_valid the cycle after avg_valid=1 and avg_ready=1 unless a new result loads in that same cycle.
REQ-018 SHALL, when a result completes while the output register is full and not draining, discard the result, keep the held result, and increment drop_count (saturate at 255); the channel accumulator still resets.
REQ-019 SHALL, on clear=1, zero all accumulators and counters next cycle, discard any sample in that cycle, and leave output register and drop_count unchanged.
REQ-020 SHALL handle samples of different channels interleaved arbitrarily, each channel independent.

Reset
REQ-021 SHALL, with reset_reset_n=0 at a clock edge, set avg_valid=0, avg_channel=0, avg_data=0, drop_count=0, all accumulators and counters 0; reset overrides clear and rsp_valid.
REQ-022 SHALL discard any partial accumulation on reset mid-block.

Structure
REQ-023 SHALL place DATA_W=12, CH_W=5, DROP_W=8 and the default LOG2_N in shared package adc_avg_pkg.
REQ-024 SHALL implement the output holding register (load, hold, drain, full indication) as sub-module adc_avg_out_reg.
REQ-025 SHALL store accumulators/counters as register arrays indexed by channel, single read-modify-write per cycle.

Verification
REQ-026 SHALL cover: ch2, 16 samples of 100, avg_ready=1 -> one avg_valid pulse, avg_channel=2, avg_data=100, one cycle after 16th sample.
REQ-027 SHALL cover: ch0 ramp 0..15 -> avg_data=7 (sum 120>>4).
REQ-028 SHALL cover: avg_ready=0, ch1 16x200 then ch3 16x300 -> held avg_data=200 ch1, drop_count=1; avg_ready=1 then drains 200.
REQ-029 SHALL cover: ch9 samples (NUM_CH=8) interleaved with 16 ch4 samples of 4095 -> single result ch4, avg_data=4095, ch9 ignored.
REQ-030 SHALL cover: 8 ch5 samples of 1000, reset (or clear) one cycle, then 16 ch5 samples of 50 -> avg_data=50, no other result.
REQ-031 SHALL cover: drop_count driven past 255 -> holds 255.
